// File: rtl/rotate_pipe_stage.sv
// rtl/rotate_pipe_stage.sv - two-stage valid/ready pipeline around a 4-bit rotator
//
// Purpose:
//   Stage 1 registers a rotate request (operand, amount, direction) and drives
//   the external combinational rotator. Stage 2 captures the rotator output
//   for the requested direction and presents it downstream. op_count counts
//   completed output handshakes for debug.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   upstream request valid
//   in_ready   stage 1 can accept this cycle
//   in_data    operand to rotate
//   in_shamt   rotate amount
//   in_dir     0 = rotate right, 1 = rotate left
//   rot_a      to rotator operand (stage-1 data register)
//   rot_shamt  to rotator amount (stage-1 shamt register)
//   rot_right  from rotator, right-rotated result
//   rot_left   from rotator, left-rotated result
//   out_valid  stage-2 result valid
//   out_ready  downstream accepts
//   out_data   rotated result
//   op_count   completed output handshakes, wrapping

module rotate_pipe_stage #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  output logic [WIDTH-1:0] rot_a,
  output logic [SHW-1:0]   rot_shamt,
  input  logic [WIDTH-1:0] rot_right,
  input  logic [WIDTH-1:0] rot_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  op_count
);

  logic             v1;
  logic [WIDTH-1:0] d1;
  logic [SHW-1:0]   s1;
  logic             dir1;
  logic             v2;
  logic [WIDTH-1:0] data2;

  logic adv2;
  logic in_xfer;
  logic out_xfer;

  // Stage 2 can take stage 1's item when it is empty or draining this cycle.
  assign adv2     = v1 & (~v2 | out_ready);
  assign in_ready = ~v1 | adv2;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = v2 & out_ready;

  assign rot_a     = d1;
  assign rot_shamt = s1;
  assign out_valid = v2;
  assign out_data  = data2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      d1   <= '0;
      s1   <= '0;
      dir1 <= 1'b0;
    end else if (in_xfer) begin
      v1   <= 1'b1;
      d1   <= in_data;
      s1   <= in_shamt;
      dir1 <= in_dir;
    end else if (adv2) begin
      // Payload registers keep their last value; only the valid bit drops.
      v1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2    <= 1'b0;
      data2 <= '0;
    end else if (adv2) begin
      v2    <= 1'b1;
      data2 <= dir1 ? rot_left : rot_right;
    end else if (out_xfer) begin
      v2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (out_xfer) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rotate_pipe_stage.sv
// tb/tb_rotate_pipe_stage.sv - directed and randomised checks for rotate_pipe_stage
module tb_rotate_pipe_stage;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_shamt;
  logic       in_dir;
  logic [3:0] rot_a;
  logic [1:0] rot_shamt;
  logic [3:0] rot_right;
  logic [3:0] rot_left;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [7:0] op_count;

  int         n_vec;
  int         n_err;
  int         ops;
  int         max_occ;
  logic [3:0] exp_q[$];
  logic       stalled_prev;
  logic [3:0] held_data;

  rotate_pipe_stage #(.WIDTH(4), .SHW(2), .CNTW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_dir    (in_dir),
    .rot_a     (rot_a),
    .rot_shamt (rot_shamt),
    .rot_right (rot_right),
    .rot_left  (rot_left),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rotr(input logic [3:0] x, input int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = x[(i + k) % 4];
    return r;
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] x, input int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = x[(i + 4 - k) % 4];
    return r;
  endfunction

  // Combinational rotator the stage is wrapped around.
  assign rot_right = rotr(rot_a, int'(rot_shamt));
  assign rot_left  = rotl(rot_a, int'(rot_shamt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, then evaluate the handshakes that the next
  // rising edge will commit.
  task automatic step(input logic iv, input logic [3:0] d, input logic [1:0] s,
                      input logic dr, input logic ordy, input logic [3:0] exp,
                      output logic acc);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_shamt  = s;
    in_dir    = dr;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (out_valid && stalled_prev) check("hold", out_data, held_data);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious", out_valid, 0);
      else check("out", out_data, exp_q.pop_front());
      ops++;
    end
    stalled_prev = out_valid && !out_ready;
    held_data    = out_data;
    if (acc) exp_q.push_back(exp);
    if (exp_q.size() > max_occ) max_occ = exp_q.size();
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 4'h0, 2'd0, 1'b0, ordy, 4'h0, acc);
  endtask

  task automatic send(input logic [3:0] d, input logic [1:0] s, input logic dr,
                      input logic [3:0] exp);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, d, s, dr, 1'b1, exp, acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    idle(1'b1);
  endtask

  initial begin
    logic       acc;
    logic [3:0] d;
    logic [1:0] s;
    logic       dr;
    int         accepted;
    int         cycles;

    n_vec = 0; n_err = 0; ops = 0; max_occ = 0;
    stalled_prev = 1'b0; held_data = 4'h0;
    in_valid = 1'b0; in_data = 4'h0; in_shamt = 2'd0; in_dir = 1'b0; out_ready = 1'b0;
    reset_n = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_op_count", op_count, 0);
    check("rst_rot_a", rot_a, 0);
    check("rst_rot_shamt", rot_shamt, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: latency of a single request
    step(1'b1, 4'b1001, 2'd1, 1'b0, 1'b1, 4'b1100, acc);
    check("t1_acc", acc, 1);
    idle(1'b1);
    check("t1_valid_n1", out_valid, 0);
    check("t1_rot_a", rot_a, 4'b1001);
    idle(1'b1);
    check("t1_valid_n2", out_valid, 1);
    check("t1_data", out_data, 4'b1100);
    idle(1'b1);
    check("t1_op_count", op_count, 1);

    // 2: direction and amount corners
    send(4'b1001, 2'd1, 1'b1, 4'b0011);
    send(4'b0001, 2'd3, 1'b0, 4'b0010);
    send(4'b0110, 2'd2, 1'b0, 4'b1001);
    send(4'b0110, 2'd2, 1'b1, 4'b1001);
    send(4'b1011, 2'd0, 1'b1, 4'b1011);
    drain();
    check("t2_op_count", op_count, 6);

    // 3: back-pressure fills both stages, third request stalls
    step(1'b1, 4'b1010, 2'd1, 1'b0, 1'b0, 4'b0101, acc);
    check("t3_acc0", acc, 1);
    step(1'b1, 4'b0011, 2'd1, 1'b1, 1'b0, 4'b0110, acc);
    check("t3_acc1", acc, 1);
    step(1'b1, 4'b1000, 2'd2, 1'b1, 1'b0, 4'b0010, acc);
    check("t3_acc2", acc, 0);
    check("t3_in_ready", in_ready, 0);
    check("t3_data", out_data, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1000, 2'd2, 1'b1, 1'b0, 4'b0010, acc);
      check("t3_stall_acc", acc, 0);
      check("t3_rot_a", rot_a, 4'b0011);
    end
    send(4'b1000, 2'd2, 1'b1, 4'b0010);
    drain();
    check("t3_op_count", op_count, 9);

    // 4: full-rate stream
    for (int i = 0; i < 16; i++) begin
      d  = 4'(i);
      s  = 2'(i % 4);
      dr = 1'(i % 2);
      step(1'b1, d, s, dr, 1'b1, dr ? rotl(d, int'(s)) : rotr(d, int'(s)), acc);
      check("t4_acc", acc, 1);
      if (i >= 2) check("t4_thru", out_valid, 1);
    end
    drain();
    check("t4_op_count", op_count, 25);

    // 5: random valid/ready against the scoreboard
    accepted = 0;
    cycles   = 0;
    max_occ  = 0;
    while (accepted < 1000 && cycles < 20000) begin
      d  = 4'($urandom_range(0, 15));
      s  = 2'($urandom_range(0, 3));
      dr = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), d, s, dr, 1'($urandom_range(0, 1)),
           dr ? rotl(d, int'(s)) : rotr(d, int'(s)), acc);
      if (acc) accepted++;
      cycles++;
    end
    drain();
    check("t5_accepted", accepted, 1000);
    check("t5_max_occ", max_occ <= 2, 1);
    check("t5_op_count", op_count, ops % 256);

    // 5b: counter wrap
    for (int i = 0; i < 300 && (ops % 256) != 255; i++) begin
      send(4'h1, 2'd1, 1'b1, 4'h2);
      drain();
    end
    check("t5_cnt_255", op_count, 255);
    send(4'h1, 2'd1, 1'b1, 4'h2);
    drain();
    check("t5_cnt_wrap", op_count, 0);

    // 6: asynchronous reset with both stages occupied
    step(1'b1, 4'b0101, 2'd1, 1'b1, 1'b0, 4'b1010, acc);
    step(1'b1, 4'b0111, 2'd1, 1'b0, 1'b0, 4'b1011, acc);
    idle(1'b0);
    check("t6_full", in_ready, 0);
    check("t6_valid_pre", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_valid_rst", out_valid, 0);
    check("t6_ready_rst", in_ready, 1);
    check("t6_cnt_rst", op_count, 0);
    exp_q.delete();
    ops = 0;
    stalled_prev = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      check("t6_no_stale", out_valid, 0);
    end
    send(4'b1001, 2'd1, 1'b0, 4'b1100);
    drain();
    check("t6_op_count", op_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
